muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Parametrised iterative multiply/divide unit for the execute stage of the pipelined MIPS core. It replaces the fixed 32-bit multiplier and adds signed/unsigned radix-2 restoring division. Results appear as HI/LO halves for the execute output mux. The unit has a Busy/Valid handshake so the hazard unit can stall dependent mfhi/mflo, and an Abort input so a pipeline flush can cancel work in flight.

## Interface
- WIDTH, 32, operand width; Hi/Lo are each WIDTH bits.
- Clk  input  1  rising-edge clock.
- Rst  input  1  synchronous, active-high reset.
- Start  input  1  one-cycle request; accepted only when Busy=0.
- Op  input  1  0 = multiply, 1 = divide; sampled with Start.
- Sign  input  1  1 = signed two's-complement, 0 = unsigned; sampled with Start.
- SrcA  input  WIDTH  multiplicand or dividend; sampled with Start.
- SrcB  input  WIDTH  multiplier or divisor; sampled with Start.
- Abort  input  1  cancels any operation in flight; returns the unit to IDLE.
- Busy  output  1  high in RUN and FIXUP.
- Valid  output  1  high in DONE; Hi/Lo/Err are stable while high.
- Hi  output  WIDTH  upper product half, or remainder.
- Lo  output  WIDTH  lower product half, or quotient.
- Err  output  1  divide by zero, or divide requested while divide is compiled out.

## Operation
- States are IDLE, RUN, FIXUP and DONE.
- **IDLE or DONE, on Start:**
  - Latch |SrcA|, |SrcB| (magnitudes only when Sign=1), Op, and the result-sign bits.
  - Clear the internal 2·WIDTH accumulator and go to RUN with the counter at WIDTH-1.
- **Multiply:** shift-add, one multiplier bit per cycle, LSB first, into a 2·WIDTH accumulator.
- **Divide:** restoring, one quotient bit per cycle, MSB first.
  - Shift the remainder left by one and subtract the divisor.
  - If the result is non-negative, keep it and set the quotient bit to 1; otherwise restore the remainder.
- **RUN → FIXUP:** when the counter reaches 0.
- **FIXUP (Sign=1 only):**
  - Multiply: negate the 2·WIDTH product when the operand signs differ.
  - Divide: negate the quotient when the operand signs differ; give the remainder the sign of the dividend.
  - Then go to DONE.
- **Signed divide of most-negative by -1:** Lo = most-negative value, Hi = 0. This is the natural wrap; no Err.
- **Divide by zero (SrcB == 0 with Op=1):** detected at Start. Go to DONE on the next cycle with Hi = SrcA, Lo = all ones, Err = 1.
- **DONE:** Hi/Lo/Err hold until the next accepted Start, Abort or Rst.
- **Start while Busy=1:** ignored; no state change.
- **Abort:** in any state, go to IDLE next cycle and clear Valid and Err. Hi/Lo go to 0.
- **Abort and Start in the same cycle:** Abort wins; the Start is dropped.
- **Rst:** all state and outputs go to 0, state goes to IDLE. Rst has priority over Abort and Start.

## Timing
- Reset values: Busy=0, Valid=0, Hi=0, Lo=0, Err=0, state IDLE.
- Start sampled at edge 0:
  - Busy=1 from cycle 1 through cycle WIDTH+1 (WIDTH RUN cycles plus 1 FIXUP cycle).
  - Valid=1 from cycle WIDTH+2.
  - FIXUP is present for unsigned operations too, so latency is fixed at WIDTH+2.
- Divide by zero: Valid=1 at cycle 1; Busy stays 0.
- Start accepted in DONE: Valid drops at cycle 1; the new result appears at WIDTH+2. Back-to-back throughput is one operation per WIDTH+2 cycles.
- Valid is a level, not a pulse.
- Hi/Lo are undefined-but-stable while Busy=1. Consumers must qualify them with Valid.

## Configuration
- MULDIV_DIV_EN defined: full divider datapath compiled in, as described above.
- MULDIV_DIV_EN undefined:
  - No divider logic is built.
  - A Start with Op=1 goes to DONE after 1 cycle with Hi=0, Lo=0, Err=1.
  - Multiply behaviour and latency are unchanged.

## Test plan
- **Unsigned multiply:** WIDTH=32, Op=0, Sign=0, SrcA=0xFFFFFFFF, SrcB=0x2 → Valid at cycle 34, Hi=0x00000001, Lo=0xFFFFFFFE, Err=0.
- **Signed multiply:** Sign=1, SrcA=-7 (0xFFFFFFF9), SrcB=3 → Hi=0xFFFFFFFF, Lo=0xFFFFFFEB.
- **Signed divide:** Op=1, Sign=1, SrcA=-17, SrcB=5 → Lo=-3 (0xFFFFFFFD), Hi=-2 (0xFFFFFFFE), Err=0.
- **Overflow divide:** SrcA=0x80000000, SrcB=-1, signed → Lo=0x80000000, Hi=0.
- **Divide by zero:** SrcA=0x1234, SrcB=0 → Valid at cycle 1, Hi=0x1234, Lo=0xFFFFFFFF, Err=1, Busy never high.
  - Repeat with MULDIV_DIV_EN undefined and SrcB=5 → Valid at cycle 1, Hi=Lo=0, Err=1.
- **Control priority:**
  - Abort at cycle 10 of a multiply → Busy=0 and Valid=0 at cycle 11, and stays IDLE.
  - Start during Busy → ignored, and the original result is correct.
  - Abort and Start in the same cycle → IDLE.
  - Rst mid-RUN → all outputs 0 on the next cycle.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative shift-add multiplier and radix-2 restoring divider, fixed WIDTH+2 cycle latency.
// Divider datapath is built only when MULDIV_DIV_EN is defined; otherwise divide requests return Err.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic             Op,
    input  logic             Sign,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic             Abort,
    output logic             Busy,
    output logic             Valid,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             Err
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, FIXUP, DONE} state_t;
    state_t state, state_nxt;

    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   opa, opb;
    logic [2*WIDTH-1:0] acc, acc_step, prod_fix;
    logic               neg_q;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   hi_fix, lo_fix;

    // quick: request resolved at Start without iterating (divide by zero / divider absent)
    logic               quick;
    logic [WIDTH-1:0]   quick_hi, quick_lo;

`ifdef MULDIV_DIV_EN
    logic               op_div, neg_r;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH+1:0]   rem_diff;
    logic [WIDTH-1:0]   rem_new;

    assign quick    = Op && (SrcB == '0);
    assign quick_hi = SrcA;
    assign quick_lo = '1;
    assign rem_sh   = {acc[2*WIDTH-1:WIDTH], opa[WIDTH-1]};
    assign rem_diff = {1'b0, rem_sh} - {2'b00, opb};
    assign rem_new  = rem_diff[WIDTH+1] ? rem_sh[WIDTH-1:0] : rem_diff[WIDTH-1:0];
`else
    assign quick    = Op;
    assign quick_hi = '0;
    assign quick_lo = '0;
`endif

    assign mag_a   = (Sign && SrcA[WIDTH-1]) ? -SrcA : SrcA;
    assign mag_b   = (Sign && SrcB[WIDTH-1]) ? -SrcB : SrcB;
    assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (opb[0] ? {1'b0, opa} : '0);
    assign prod_fix = neg_q ? -acc : acc;

    always_comb begin
        acc_step = {mul_sum, acc[WIDTH-1:1]};
        {hi_fix, lo_fix} = prod_fix;
`ifdef MULDIV_DIV_EN
        if (op_div) begin
            acc_step = {rem_new, acc[WIDTH-2:0], ~rem_diff[WIDTH+1]};
            hi_fix   = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
            lo_fix   = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        end
`endif
    end

    always_ff @(posedge Clk) begin
        if (Rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (Start) state_nxt = quick ? DONE : RUN;
            RUN:        if (cnt == '0) state_nxt = FIXUP;
            FIXUP:      state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
        if (Abort) state_nxt = IDLE;
    end

    assign Busy  = (state == RUN) || (state == FIXUP);
    assign Valid = (state == DONE);

    always_ff @(posedge Clk) begin
        if (Rst || Abort) begin
            cnt   <= '0;
            opa   <= '0;
            opb   <= '0;
            acc   <= '0;
            neg_q <= 1'b0;
            Hi    <= '0;
            Lo    <= '0;
            Err   <= 1'b0;
`ifdef MULDIV_DIV_EN
            op_div <= 1'b0;
            neg_r  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (Start) begin
                        Err <= quick;
                        if (quick) begin
                            Hi <= quick_hi;
                            Lo <= quick_lo;
                        end else begin
                            cnt   <= CW'(WIDTH - 1);
                            opa   <= mag_a;
                            opb   <= mag_b;
                            acc   <= '0;
                            neg_q <= Sign && (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
`ifdef MULDIV_DIV_EN
                            op_div <= Op;
                            neg_r  <= Sign && SrcA[WIDTH-1];
`endif
                        end
                    end
                end
                RUN: begin
                    acc <= acc_step;
                    cnt <= cnt - CW'(1);
`ifdef MULDIV_DIV_EN
                    // divide walks dividend bits MSB-first; multiply walks multiplier LSB-first
                    if (op_div) opa <= opa << 1;
                    else        opb <= opb >> 1;
`else
                    opb <= opb >> 1;
`endif
                end
                FIXUP: begin
                    Hi <= hi_fix;
                    Lo <= lo_fix;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: cycle-level reference model plus hand-computed literal checks.
module tb_muldiv_unit;
    localparam int WIDTH = 32;

    logic             Clk = 1'b0;
    logic             Rst, Start, Op, Sign, Abort;
    logic [WIDTH-1:0] SrcA, SrcB;
    logic             Busy, Valid, Err;
    logic [WIDTH-1:0] Hi, Lo;

    int n_checks = 0;
    int n_fail   = 0;
    logic chk_en = 1'b0;

    muldiv_unit #(.WIDTH(WIDTH)) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .Sign(Sign),
        .SrcA(SrcA), .SrcB(SrcB), .Abort(Abort),
        .Busy(Busy), .Valid(Valid), .Hi(Hi), .Lo(Lo), .Err(Err)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Architectural result of one request, from plain arithmetic.
    task automatic model_calc(input logic op, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                              output logic quick, output logic [31:0] hi, output logic [31:0] lo,
                              output logic err);
        longint sa, sb, sp;
        longint unsigned ua, ub, up;
        quick = 1'b0;
        err   = 1'b0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        if (!op) begin
            if (sgn) begin sp = sa * sb; {hi, lo} = sp; end
            else     begin up = ua * ub; {hi, lo} = up; end
        end else begin
`ifdef MULDIV_DIV_EN
            if (b == 32'h0) begin
                quick = 1'b1; err = 1'b1; hi = a; lo = 32'hFFFF_FFFF;
            end else if (sgn) begin
                sp = sa / sb; lo = sp[31:0];
                sp = sa % sb; hi = sp[31:0];
            end else begin
                lo = a / b; hi = a % b;
            end
`else
            quick = 1'b1; err = 1'b1; hi = 32'h0; lo = 32'h0;
`endif
        end
    endtask

    // Cycle-level model: expected Busy/Valid and, when defined, Hi/Lo/Err.
    logic        m_busy, m_valid, m_known, m_err, p_err, q;
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    int          m_rem;

    always @(posedge Clk) begin
        if (Rst || Abort) begin
            m_busy = 0; m_valid = 0; m_known = 1; m_err = 0; m_hi = 0; m_lo = 0; m_rem = 0;
        end else if (Start && !m_busy) begin
            model_calc(Op, Sign, SrcA, SrcB, q, p_hi, p_lo, p_err);
            if (q) begin
                m_valid = 1; m_known = 1; m_hi = p_hi; m_lo = p_lo; m_err = p_err;
            end else begin
                m_busy = 1; m_valid = 0; m_known = 0; m_rem = WIDTH + 1;
            end
        end else if (m_busy) begin
            m_rem--;
            if (m_rem == 0) begin
                m_busy = 0; m_valid = 1; m_known = 1; m_hi = p_hi; m_lo = p_lo; m_err = p_err;
            end
        end
    end

    always @(negedge Clk) begin
        if (chk_en) begin
            check("busy", {63'h0, Busy}, {63'h0, m_busy});
            check("valid", {63'h0, Valid}, {63'h0, m_valid});
            if (m_known) begin
                check("hi", {32'h0, Hi}, {32'h0, m_hi});
                check("lo", {32'h0, Lo}, {32'h0, m_lo});
                check("err", {63'h0, Err}, {63'h0, m_err});
            end
        end
    end

    // Leaves the caller just after the edge that sampled Start (cycle 1).
    task automatic op_start(input logic op, input logic sgn, input logic [31:0] a, input logic [31:0] b);
        @(posedge Clk); #1;
        Start = 1; Op = op; Sign = sgn; SrcA = a; SrcB = b;
        @(posedge Clk); #1;
        Start = 0;
    endtask

    task automatic wait_valid(input int from, output int cyc);
        cyc = from;
        while (!Valid && cyc < 200) begin
            @(posedge Clk); #1;
            cyc++;
        end
    endtask

    task automatic run_op(input string name, input logic op, input logic sgn,
                          input logic [31:0] a, input logic [31:0] b, input int lat,
                          input logic [31:0] hi, input logic [31:0] lo, input logic err);
        int cyc;
        op_start(op, sgn, a, b);
        wait_valid(1, cyc);
        check({name, "_lat"}, 64'(cyc), 64'(lat));
        check({name, "_hi"}, {32'h0, Hi}, {32'h0, hi});
        check({name, "_lo"}, {32'h0, Lo}, {32'h0, lo});
        check({name, "_err"}, {63'h0, Err}, {63'h0, err});
    endtask

    initial begin
        int cyc;
        Rst = 1; Start = 0; Op = 0; Sign = 0; Abort = 0; SrcA = 0; SrcB = 0;
        repeat (2) @(posedge Clk);
        #1 Rst = 0;
        chk_en = 1;
        check("rst_busy", {63'h0, Busy}, 64'h0);
        check("rst_valid", {63'h0, Valid}, 64'h0);
        check("rst_hilo", {Hi, Lo}, 64'h0);
        check("rst_err", {63'h0, Err}, 64'h0);

        run_op("umul", 0, 0, 32'hFFFF_FFFF, 32'h2, 34, 32'h1, 32'hFFFF_FFFE, 0);
        run_op("smul", 0, 1, 32'hFFFF_FFF9, 32'h3, 34, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0);
        run_op("smul_min", 0, 1, 32'h8000_0000, 32'h8000_0000, 34, 32'h4000_0000, 32'h0, 0);
`ifdef MULDIV_DIV_EN
        run_op("sdiv", 1, 1, 32'hFFFF_FFEF, 32'h5, 34, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 0);
        run_op("sdiv_negb", 1, 1, 32'd17, 32'hFFFF_FFFB, 34, 32'h2, 32'hFFFF_FFFD, 0);
        run_op("sdiv_ovf", 1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'h0, 32'h8000_0000, 0);
        run_op("udiv", 1, 0, 32'd100, 32'd7, 34, 32'd2, 32'd14, 0);
        run_op("udiv_big", 1, 0, 32'hFFFF_FFFF, 32'h10, 34, 32'hF, 32'h0FFF_FFFF, 0);
        run_op("div0", 1, 0, 32'h1234, 32'h0, 1, 32'h1234, 32'hFFFF_FFFF, 1);
`else
        run_op("sdiv_off", 1, 1, 32'hFFFF_FFEF, 32'h5, 1, 32'h0, 32'h0, 1);
        run_op("div_off", 1, 0, 32'h1234, 32'h5, 1, 32'h0, 32'h0, 1);
        run_op("div0_off", 1, 0, 32'h1234, 32'h0, 1, 32'h0, 32'h0, 1);
`endif
        check("quick_nobusy", {63'h0, Busy}, 64'h0);

        // Start while busy must be ignored
        op_start(0, 0, 32'd1234, 32'd5678);
        repeat (4) @(posedge Clk);
        #1 Start = 1; Op = 1; Sign = 1; SrcA = 32'd3; SrcB = 32'd0;
        @(posedge Clk); #1 Start = 0;
        wait_valid(6, cyc);
        check("busy_start_lat", 64'(cyc), 64'd34);
        check("busy_start_res", {Hi, Lo}, 64'h0000_0000_006A_E9BC);
        check("busy_start_err", {63'h0, Err}, 64'h0);

        // Abort during cycle 10 of a multiply
        op_start(0, 0, 32'h55, 32'h77);
        repeat (9) @(posedge Clk);
        #1 check("abort_pre_busy", {63'h0, Busy}, 64'h1);
        Abort = 1;
        @(posedge Clk); #1 Abort = 0;
        check("abort_busy", {63'h0, Busy}, 64'h0);
        check("abort_valid", {63'h0, Valid}, 64'h0);
        check("abort_hilo", {Hi, Lo}, 64'h0);
        repeat (5) @(posedge Clk);
        #1 check("abort_idle", {62'h0, Busy, Valid}, 64'h0);

        // Abort and Start together while a result is held
        run_op("umul2", 0, 0, 32'd6, 32'd7, 34, 32'h0, 32'd42, 0);
        Start = 1; Abort = 1; Op = 0; SrcA = 32'd9; SrcB = 32'd9;
        @(posedge Clk); #1 Start = 0; Abort = 0;
        check("abst_busy", {63'h0, Busy}, 64'h0);
        check("abst_valid", {63'h0, Valid}, 64'h0);
        check("abst_hilo", {Hi, Lo}, 64'h0);
        repeat (3) @(posedge Clk);
        #1 check("abst_idle", {62'h0, Busy, Valid}, 64'h0);

        // Reset mid-RUN
        run_op("umul3", 0, 0, 32'h1_0000, 32'h1_0000, 34, 32'h1, 32'h0, 0);
        op_start(0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (4) @(posedge Clk);
        #1 Rst = 1;
        @(posedge Clk); #1 Rst = 0;
        check("rstrun_out", {Hi, Lo}, 64'h0);
        check("rstrun_flags", {61'h0, Busy, Valid, Err}, 64'h0);
        run_op("after_rst", 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 32'h0, 32'h1, 0);

        repeat (3) @(posedge Clk);
        chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d checks, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end
endmodule
